// File: rtl/riscv_pkg.sv
// Shared opcode/funct3/ALU constants, pipeline-register types and small
// combinational helpers for the 5-stage RV32I core.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        a_pc;
    logic        b_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  funct3;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] wdata;
  } mem_wb_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    case (i[6:0])
      OP_STORE:         return {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC: return {i[31:12], 12'd0};
      OP_JAL:           return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default:          return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << b[4:0];
      ALU_SLT:   return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  return {31'd0, a < b};
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      ALU_PASSB: return b;
      default:   return a + b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core.sv
// 5-stage in-order RV32I pipeline: EX-resolved control flow with 2-cycle
// flush, EX/MEM > MEM/WB forwarding, one-cycle load-use stall.
module riscv_core (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] dev_addr_o,
  output logic [31:0] dev_wdata_o
);
  import riscv_pkg::*;

  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, dec;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [31:0] pc, pc_d;
  logic [31:0] rf_rd1, rf_rd2, instr;
  logic        use_rs1, use_rs2, load_use;
  logic [31:0] op_a, op_b, alu_a, alu_b, alu_res, target;
  logic        redirect, is_dev;
  logic [31:0] dev_addr_q, dev_data_q;
  logic [31:0] mem_wb_io_data_pc;
  logic        unused_obs;

  assign instr = if_id_q.instr;

  riscv_regfile regs (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (mem_wb_q.reg_write),
    .waddr_i  (mem_wb_q.rd),
    .wdata_i  (mem_wb_q.wdata),
    .raddr1_i (instr[19:15]),
    .raddr2_i (instr[24:20]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  // ID: unknown opcodes keep all control low and flow through as NOPs.
  always_comb begin
    dec         = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec.valid   = if_id_q.valid;
    dec.pc      = if_id_q.pc;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.rs1_val = rf_rd1;
    dec.rs2_val = rf_rd2;
    dec.imm     = imm_gen(instr);
    dec.funct3  = instr[14:12];
    dec.alu_op  = ALU_ADD;
    if (if_id_q.valid) begin
      case (instr[6:0])
        OP_LUI:    begin dec.alu_op = ALU_PASSB; dec.b_imm = 1'b1; dec.reg_write = 1'b1; end
        OP_AUIPC:  begin dec.a_pc = 1'b1; dec.b_imm = 1'b1; dec.reg_write = 1'b1; end
        OP_JAL:    begin dec.jal = 1'b1; dec.reg_write = 1'b1; end
        OP_JALR:   begin dec.jalr = 1'b1; dec.reg_write = 1'b1; use_rs1 = 1'b1; end
        OP_BRANCH: begin dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OP_LOAD:   begin dec.b_imm = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1; use_rs1 = 1'b1; end
        OP_STORE:  begin dec.b_imm = 1'b1; dec.mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OP_IMM: begin
          dec.alu_op    = alu_decode(instr[14:12], instr[30] && instr[14:12] == F3_SR);
          dec.b_imm     = 1'b1;
          dec.reg_write = 1'b1;
          use_rs1       = 1'b1;
        end
        OP_OP: begin
          dec.alu_op    = alu_decode(instr[14:12], instr[30]);
          dec.reg_write = 1'b1;
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load_use = id_ex_q.mem_read && id_ex_q.rd != 5'd0 &&
                    ((use_rs1 && dec.rs1 == id_ex_q.rd) || (use_rs2 && dec.rs2 == id_ex_q.rd));

  // EX
  always_comb begin
    op_a = id_ex_q.rs1_val;
    if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1)
      op_a = ex_mem_q.result;
    else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1)
      op_a = mem_wb_q.wdata;
    op_b = id_ex_q.rs2_val;
    if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2)
      op_b = ex_mem_q.result;
    else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2)
      op_b = mem_wb_q.wdata;

    alu_a    = id_ex_q.a_pc ? id_ex_q.pc : op_a;
    alu_b    = id_ex_q.b_imm ? id_ex_q.imm : op_b;
    alu_res  = alu(id_ex_q.alu_op, alu_a, alu_b);
    redirect = id_ex_q.jal || id_ex_q.jalr ||
               (id_ex_q.branch && br_taken(id_ex_q.funct3, op_a, op_b));
    target   = id_ex_q.jalr ? ((op_a + id_ex_q.imm) & ~32'd1) : (id_ex_q.pc + id_ex_q.imm);

    ex_mem_d            = '0;
    ex_mem_d.valid      = id_ex_q.valid;
    ex_mem_d.pc         = id_ex_q.pc;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.result     = (id_ex_q.jal || id_ex_q.jalr) ? id_ex_q.pc + 32'd4 : alu_res;
    ex_mem_d.store_data = op_b;
  end

  // MEM: the upper half of the address space belongs to the device port.
  assign is_dev       = ex_mem_q.result[31];
  assign dmem_addr_o  = ex_mem_q.result;
  assign dmem_we_o    = ex_mem_q.mem_write && !is_dev;
  assign dmem_wdata_o = ex_mem_q.store_data;

  always_comb begin
    mem_wb_d           = '0;
    mem_wb_d.valid     = ex_mem_q.valid;
    mem_wb_d.pc        = ex_mem_q.pc;
    mem_wb_d.rd        = ex_mem_q.rd;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.wdata     = !ex_mem_q.mem_read ? ex_mem_q.result :
                         (is_dev ? '0 : dmem_rdata_i);
  end

  always_comb begin
    pc_d           = pc + 32'd4;
    if_id_d        = '0;
    if_id_d.valid  = 1'b1;
    if_id_d.pc     = pc;
    if_id_d.instr  = imem_instr_i;
    id_ex_d        = dec;
    if (redirect) begin
      pc_d    = target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (load_use) begin
      pc_d    = pc;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc         <= '0;
      if_id_q    <= '0;
      id_ex_q    <= '0;
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      dev_addr_q <= '0;
      dev_data_q <= '0;
    end else begin
      pc       <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      if (ex_mem_q.mem_write && is_dev) begin
        dev_addr_q <= ex_mem_q.result;
        dev_data_q <= ex_mem_q.store_data;
      end
    end
  end

  assign imem_addr_o       = pc;
  assign dev_addr_o        = dev_addr_q;
  assign dev_wdata_o       = dev_data_q;
  assign mem_wb_io_data_pc = mem_wb_q.valid ? mem_wb_q.pc : '0;
  // Observation-only: WB pc is probed hierarchically, never consumed.
  assign unused_obs        = ^mem_wb_io_data_pc;
endmodule

// File: rtl/riscv_dmem.sv
// Word-addressed data RAM: combinational read, write on the clock edge.
// No reset so preloaded contents survive a core reset.
module riscv_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] DMEM [DEPTH];
  logic        unused_addr;

  always_ff @(posedge clk_i) begin
    if (we_i) DMEM[addr_i[AW+1:2]] <= wdata_i;
  end

  assign rdata_o     = DMEM[addr_i[AW+1:2]];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
endmodule

// File: rtl/riscv_imem.sv
// Word-addressed instruction ROM, read combinationally; contents are
// loaded by backdoor and untouched by reset.
module riscv_imem #(
  parameter int DEPTH = 256
) (
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] IMEM [DEPTH];
  logic        unused_addr;

  assign instr_o     = IMEM[addr_i[AW+1:2]];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
endmodule

// File: rtl/riscv_regfile.sv
// 32x32 register file; WB write is bypassed to the ID read ports so a
// same-cycle read sees the value being written.
module riscv_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] regs [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 :
                    (we_i && waddr_i == raddr1_i) ? wdata_i : regs[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 :
                    (we_i && waddr_i == raddr2_i) ? wdata_i : regs[raddr2_i];
endmodule

// File: rtl/top.sv
// RV32I system: core plus word-addressed instruction and data memories.
module top #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);
  logic [31:0] io_imem_instr, imem_addr;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic [31:0] device_io_addr, device_io_write_data;
  logic        unused_obs;

  riscv_core U_CPU (
    .clk_i        (clk),
    .rst_i        (reset),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (io_imem_instr),
    .dmem_addr_o  (dmem_addr),
    .dmem_we_o    (dmem_we),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rdata_i (dmem_rdata),
    .dev_addr_o   (device_io_addr),
    .dev_wdata_o  (device_io_write_data)
  );

  riscv_imem #(.DEPTH(IMEM_DEPTH)) U_IM (
    .addr_i  (imem_addr),
    .instr_o (io_imem_instr)
  );

  riscv_dmem #(.DEPTH(DMEM_DEPTH)) U_DM (
    .clk_i   (clk),
    .addr_i  (dmem_addr),
    .we_i    (dmem_we),
    .wdata_i (dmem_wdata),
    .rdata_o (dmem_rdata)
  );

  // Device port has no consumer here; it is observed hierarchically.
  assign unused_obs = ^{device_io_addr, device_io_write_data};
endmodule

// File: tb/tb_top.sv
// Directed program bench: backdoor-loads IMEM, checks WB pc trace,
// register/memory results, device store and reset behaviour.
module tb_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] p1 [15];
  logic [31:0] p2 [6];
  logic [31:0] wb_exp [19];
  logic [31:0] dm1;

  top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  initial begin
    p1 = '{32'h00500093,   // 00 addi x1,x0,5
           32'h00308113,   // 04 addi x2,x1,3
           32'h00000463,   // 08 beq  x0,x0,+8
           32'h06300313,   // 0c addi x6,x0,99 (skipped)
           32'h00202023,   // 10 sw   x2,0(x0)
           32'h00002183,   // 14 lw   x3,0(x0)
           32'h00318233,   // 18 add  x4,x3,x3
           32'h800002B7,   // 1c lui  x5,0x80000
           32'h010000EF,   // 20 jal  x1,+16
           32'h04D00313,   // 24 addi x6,x0,77 (skipped)
           32'h04D00313,   // 28
           32'h04D00313,   // 2c
           32'h00700013,   // 30 addi x0,x0,7
           32'h00100413,   // 34 addi x8,x0,1
           32'h0000006F};  // 38 jal  x0,0
    p2 = '{32'h00500093,   // 00 addi x1,x0,5
           32'h800002B7,   // 04 lui  x5,0x80000
           32'h0012A223,   // 08 sw   x1,4(x5)
           32'h00002483,   // 0c lw   x9,0(x0)
           32'h0042A503,   // 10 lw   x10,4(x5)
           32'h0000006F};  // 14 jal  x0,0
    wb_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h10, 32'h14,
               32'h0, 32'h18, 32'h1C, 32'h20, 32'h0, 32'h0, 32'h30, 32'h34, 32'h38};

    for (int i = 0; i < 256; i++) dut.U_IM.IMEM[i] = 32'h00000013;
    for (int i = 0; i < 15; i++)  dut.U_IM.IMEM[i] = p1[i];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc",       dut.U_CPU.pc, 32'h0);
    chk("rst_wb_pc",    dut.U_CPU.mem_wb_io_data_pc, 32'h0);
    chk("rst_dev_addr", dut.device_io_addr, 32'h0);
    chk("rst_dev_data", dut.device_io_write_data, 32'h0);
    chk("rst_x1",       dut.U_CPU.regs.regs[1], 32'h0);
    chk("rst_fetch",    dut.io_imem_instr, 32'h00500093);

    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 19; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) chk("pc_first_edge", dut.U_CPU.pc, 32'h4);
      chk($sformatf("wb_pc[%0d]", k + 1), dut.U_CPU.mem_wb_io_data_pc, wb_exp[k]);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("fwd_x2",      dut.U_CPU.regs.regs[2], 32'd8);
    chk("lw_x3",       dut.U_CPU.regs.regs[3], 32'd8);
    chk("loaduse_x4",  dut.U_CPU.regs.regs[4], 32'd16);
    chk("lui_x5",      dut.U_CPU.regs.regs[5], 32'h80000000);
    chk("jal_link_x1", dut.U_CPU.regs.regs[1], 32'h24);
    chk("flushed_x6",  dut.U_CPU.regs.regs[6], 32'h0);
    chk("x0_zero",     dut.U_CPU.regs.regs[0], 32'h0);
    chk("tail_x8",     dut.U_CPU.regs.regs[8], 32'h1);
    chk("sw_dmem0",    dut.U_DM.DMEM[0], 32'd8);
    chk("no_dev_addr", dut.device_io_addr, 32'h0);

    // Reset mid-run, swap in the device program, rerun from 0.
    dm1 = dut.U_DM.DMEM[1];
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_pc",    dut.U_CPU.pc, 32'h0);
    chk("midrst_wb_pc", dut.U_CPU.mem_wb_io_data_pc, 32'h0);
    chk("midrst_x1",    dut.U_CPU.regs.regs[1], 32'h0);
    for (int i = 0; i < 16; i++) dut.U_IM.IMEM[i] = 32'h00000013;
    for (int i = 0; i < 6; i++)  dut.U_IM.IMEM[i] = p2[i];
    @(posedge clk);
    #1;
    chk("midrst_pc_clk", dut.U_CPU.pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rerun_pc", dut.U_CPU.pc, 32'h4);
    repeat (15) @(posedge clk);
    #1;
    chk("p2_x1",       dut.U_CPU.regs.regs[1], 32'd5);
    chk("dev_addr",    dut.device_io_addr, 32'h80000004);
    chk("dev_data",    dut.device_io_write_data, 32'd5);
    chk("dmem1_kept",  dut.U_DM.DMEM[1], dm1);
    chk("dmem0_kept",  dut.U_DM.DMEM[0], 32'd8);
    chk("retained_x9", dut.U_CPU.regs.regs[9], 32'd8);
    chk("devload_x10", dut.U_CPU.regs.regs[10], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, meaning the number of 32-bit instruction words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, meaning the number of 32-bit data words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have no other ports; all observation is by hierarchical name.
REQ-006 SHALL expose these hierarchical names:
- U_IM.IMEM: 32-bit word array, IMEM_DEPTH entries.
- U_DM.DMEM: 32-bit word array, DMEM_DEPTH entries.
- U_CPU.pc: 32-bit fetch PC.
- U_CPU.mem_wb_io_data_pc: 32-bit PC in WB.
- U_CPU.regs.regs: 32x32 register file.
- io_imem_instr: 32-bit fetched instruction.
- device_io_addr and device_io_write_data: 32 bits each.

Function
REQ-007 SHALL be a 5-stage in-order RV32I pipeline (IF, ID, EX, MEM, WB).
REQ-008 SHALL execute LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, all OP-IMM and all OP; any other opcode executes as a NOP.
REQ-009 SHALL fetch io_imem_instr = IMEM[pc[9:2]] combinationally; memory is word-addressed, and pc[1:0] is ignored.
REQ-010 SHALL advance pc by 4 each cycle unless stalled or redirected.
REQ-011 SHALL resolve branches and jumps in EX: a taken branch, JAL or JALR loads the target into pc (JALR target bit 0 cleared) and flushes the IF/ID and ID/EX registers to bubbles (2-cycle penalty).
REQ-012 SHALL forward EX/MEM, then MEM/WB, results to EX operands, with EX/MEM having priority; the register file writes in the first half of the cycle so ID reads see the WB value.
REQ-013 SHALL stall IF and ID for exactly 1 cycle and insert an EX bubble when the instruction in ID reads the rd of an LW in EX (rd != x0).
REQ-014 SHALL keep x0 reading 0 and ignore writes to it.
REQ-015 SHALL perform LW/SW on DMEM[addr[9:2]] for addresses below 0x8000_0000; a store writes on the clock edge in MEM, and a load reads combinationally in MEM.
REQ-016 SHALL route stores with addr >= 0x8000_0000 to the device interface instead of DMEM; loads from that range return 0.
REQ-017 SHALL set device_io_addr and device_io_write_data to the MEM-stage address and store data of a device store, and hold the last values otherwise.
REQ-018 SHALL make mem_wb_io_data_pc the PC of the instruction in WB, and 0 for a bubble or flushed slot.
REQ-019 SHALL wrap out-of-range PCs and addresses modulo depth with no exception; arithmetic is 32-bit wrap-around; shifts use the low 5 bits.

Reset
REQ-020 SHALL, while reset is high, force pc=0, all pipeline registers to bubbles, mem_wb_io_data_pc=0, device_io_addr=0, device_io_write_data=0 and all registers=0.
REQ-021 SHALL NOT reset IMEM or DMEM contents, so backdoor preload and clear survive reset.
REQ-022 SHALL discard all in-flight instructions on a reset mid-operation, and fetch from 0 on the first rising edge after release.

Structure
REQ-023 SHALL place opcode, funct3 and ALU-op constants plus the pipeline-register typedefs in a shared package riscv_pkg.
REQ-024 SHALL instantiate three sub-modules: U_CPU (core), U_IM (instruction memory) and U_DM (data memory); the register file is sub-module regs inside U_CPU.

Verification
REQ-025 SHALL cover: IMEM = addi x1,x0,5; addi x2,x1,3 (back-to-back) -> x2=8 via forwarding.
REQ-026 SHALL cover: sw x2,0(x0); lw x3,0(x0); add x4,x3,x3 -> DMEM[0]=8, x4=16, with exactly one stall cycle.
REQ-027 SHALL cover: beq x0,x0,+8 at 0x8 -> instruction at 0xC never reaches WB (mem_wb_io_data_pc sequence 0x8 then 0x10).
REQ-028 SHALL cover: lui x5,0x80000; sw x1,4(x5) -> device_io_addr=0x8000_0004, device_io_write_data=5, and DMEM unchanged.
REQ-029 SHALL cover: reset pulse mid-program -> pc=0 and mem_wb_io_data_pc=0 during reset; the program reruns from 0 with the DMEM contents retained.
REQ-030 SHALL cover: jal x1,+16 at 0x20 -> x1=0x24 and next WB pc=0x30.
